keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
- Scans a 4x4 matrix keypad by driving one column at a time and sampling the rows.
- Debounces each candidate press and release.
- Emits a one-cycle key_valid pulse with a 4-bit key code per debounced press; a single pulse per press is the input contract for the calculator's operand/operator entry logic.
- Sits between the board keypad pins and the calculator control FSM, on the divided clock.

Parameters:
- SETTLE_CYC, 1000: cycles each column is driven before its rows are sampled.
- DEBOUNCE_CYC, 100000: consecutive stable cycles required to accept a press or a release (10 ms at 10 MHz).

Ports:
- clk  input  1  divided system clock.
- rst  input  1  asynchronous, active-high reset.
- row_in  input  4  row sense lines, active-high, already synchronised externally.
- col_out  output  4  one-hot active-high column drive.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key.
- key_valid  output  1  one-cycle pulse per accepted press.
- key_held  output  1  high from acceptance until the debounced release.

Behaviour:
- Reset values (asynchronous): state=SCAN, col_idx=0, col_out=4'b0001, key_code=0, key_valid=0, key_held=0, all counters 0.
- All outputs are registered. col_out is always the one-hot of col_idx; it is never all-zero and never multi-hot.
- Counter width is $clog2(max(SETTLE_CYC, DEBOUNCE_CYC)+1). Counters saturate; they never wrap.
- SCAN state:
  - The dwell counter increments each cycle.
  - At dwell==SETTLE_CYC-1, row_in is sampled and dwell clears.
  - Exactly one row bit set: capture row_idx, go to DEBOUNCE with the column held.
  - Zero bits or more than one bit set (ghost/multi-key): col_idx advances (3 wraps to 0); stay in SCAN.
- DEBOUNCE state (column held):
  - Each cycle row_in equals the captured one-hot pattern, cnt increments.
  - Any mismatch clears cnt, advances col_idx, and returns to SCAN.
  - When cnt reaches DEBOUNCE_CYC-1 on a matching cycle, go to PRESSED.
  - On that same edge: key_code={row_idx,col_idx}, key_valid=1, key_held=1.
- PRESSED state (column held):
  - key_valid is 1 only in the first cycle, then 0.
  - cnt counts consecutive cycles with the captured row bit at 0, and clears whenever the bit returns to 1.
  - Other row bits are ignored; a second key gives no event (no rollover).
  - When the release count reaches DEBOUNCE_CYC-1: key_held=0, col_idx advances, cnt clears, go to SCAN.
- key_code holds its value until the next accepted press.
- Latency: key_valid rises exactly DEBOUNCE_CYC cycles after the first matching DEBOUNCE cycle.
- Exactly one key_valid per physical press, regardless of bounce on press or release.
- Reset in any state returns everything to reset values immediately. No pending pulse survives reset.

Decomposition:
- Shared package kp_pkg:
  - state enum {SCAN, DEBOUNCE, PRESSED}.
  - constants KP_ROWS=4, KP_COLS=4, KP_CODE_W=4.
  - function onehot4_idx (returns index and a valid flag).
- One natural sub-module, kp_timer: a saturating counter with clear, enable and a terminal-count compare.
  - Instantiated once and shared by the dwell, debounce and release phases, since they are mutually exclusive.
- Everything else stays in keypad_scan_ctrl.

Test Plan (SETTLE_CYC=4, DEBOUNCE_CYC=8):
- Reset asserted mid-run -> col_out=0001, key_valid=0, key_held=0, key_code=0 in the same cycle.
- Idle, row_in=0 -> col_out steps 0001, 0010, 0100, 1000 every 4 cycles, back to 0001 after 16 cycles, no key_valid.
- row_in=0100 while col_out=0010, held 30 cycles then 0 for 12 cycles:
  - exactly one key_valid pulse with key_code=4'b1001;
  - key_held=1 from the pulse until 8 cycles after release;
  - scan then resumes at col_out=0100.
- Press bounce: row_in=0001 at col 0 for 3 cycles, then 0 -> no key_valid; col_out advances to 0010.
- Release bounce: after acceptance, release 5 cycles, re-press 2 cycles, release 8 cycles -> still only one key_valid; key_held drops only at the end of the final 8-cycle release.
- Multi-key: row_in=0011 at sample time -> ignored, no DEBOUNCE entry, column advances.
- Reset during PRESSED -> key_held=0 immediately; no key_valid within 20 cycles while row_in=0.

Source files
------------

// File: rtl/kp_pkg.sv
// Shared types, sizes and helpers for the keypad scanner.
package kp_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } kp_state_e;

    localparam int unsigned KP_ROWS   = 4;
    localparam int unsigned KP_COLS   = 4;
    localparam int unsigned KP_CODE_W = 4;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } onehot4_t;

    // Zero or multiple bits set (no key / ghosting) report valid=0.
    function automatic onehot4_t onehot4_idx(input logic [3:0] v);
        onehot4_t r;
        r.valid = 1'b1;
        r.idx   = 2'd0;
        case (v)
            4'b0001: r.idx = 2'd0;
            4'b0010: r.idx = 2'd1;
            4'b0100: r.idx = 2'd2;
            4'b1000: r.idx = 2'd3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and key-event bundle between the scanner and its neighbours.
interface keypad_scan_ctrl_if;
    import kp_pkg::*;

    logic [KP_ROWS-1:0]   row_in;
    logic [KP_COLS-1:0]   col_out;
    logic [KP_CODE_W-1:0] key_code;
    logic                 key_valid;
    logic                 key_held;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/kp_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
module kp_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc,
    output logic         at_tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_tc = (cnt_q == tc);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, row sampling, press/release debounce,
// one key_valid pulse per accepted press.
module keypad_scan_ctrl
    import kp_pkg::*;
#(
    parameter int unsigned SETTLE_CYC   = 1000,
    parameter int unsigned DEBOUNCE_CYC = 100000
) (
    input  logic                clk,
    input  logic                rst,
    keypad_scan_ctrl_if.master  kp
);

    localparam int unsigned CNT_MAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_TC   = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_TC = CNT_W'(DEBOUNCE_CYC - 1);

    kp_state_e            state_q, state_d;
    logic [1:0]           col_idx_q, col_idx_d;
    logic [1:0]           row_idx_q, row_idx_d;
    logic [KP_COLS-1:0]   col_out_q, col_out_d;
    logic [KP_CODE_W-1:0] key_code_q, key_code_d;
    logic                 key_valid_q, key_valid_d;
    logic                 key_held_q, key_held_d;

    logic             t_clr, t_en, t_at_tc;
    logic [CNT_W-1:0] t_tc;
    logic [3:0]       row_pat;
    onehot4_t         sample;

    // Dwell, debounce and release phases never overlap, so one timer serves all three.
    kp_timer #(.W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (t_clr),
        .en    (t_en),
        .tc    (t_tc),
        .at_tc (t_at_tc)
    );

    assign row_pat = 4'b0001 << row_idx_q;
    assign sample  = onehot4_idx(kp.row_in);

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;
        t_clr       = 1'b0;
        t_en        = 1'b0;
        t_tc        = SETTLE_TC;

        case (state_q)
            SCAN: begin
                if (t_at_tc) begin
                    t_clr = 1'b1;
                    if (sample.valid) begin
                        row_idx_d = sample.idx;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    t_en = 1'b1;
                end
            end
            DEBOUNCE: begin
                t_tc = DEBOUNCE_TC;
                if (kp.row_in == row_pat) begin
                    if (t_at_tc) begin
                        t_clr       = 1'b1;
                        state_d     = PRESSED;
                        key_code_d  = {row_idx_q, col_idx_q};
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                    end else begin
                        t_en = 1'b1;
                    end
                end else begin
                    t_clr     = 1'b1;
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = SCAN;
                end
            end
            PRESSED: begin
                t_tc = DEBOUNCE_TC;
                // Only the captured row matters; other rows cannot start a new event.
                if (!kp.row_in[row_idx_q]) begin
                    if (t_at_tc) begin
                        t_clr      = 1'b1;
                        key_held_d = 1'b0;
                        col_idx_d  = col_idx_q + 2'd1;
                        state_d    = SCAN;
                    end else begin
                        t_en = 1'b1;
                    end
                end else begin
                    t_clr = 1'b1;
                end
            end
            default: begin
                t_clr   = 1'b1;
                state_d = SCAN;
            end
        endcase

        col_out_d = 4'b0001 << col_idx_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            col_idx_q   <= '0;
            row_idx_q   <= '0;
            col_out_q   <= 4'b0001;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            col_out_q   <= col_out_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.col_out   = col_out_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule
